hazard_scheduler: RTL and testbench

- Central hazard and sequencing controller for the four-stage R -> C -> M -> W integer pipeline.
- Keeps shadow copies of the destination and control info for instructions in C, M and W.
- Drives per-stage stall/flush, the operand forwarding selects used by the C stage, and the W-to-R register file bypass.
- Sequences long-latency compute operations by holding C for a fixed number of cycles.

---
 rtl/hazard_scheduler.sv | 175 +++++++++++++++++
 tb/tb_hazard_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall/flush sequencing, C-stage operand forwarding and W->R
// register-file bypass for the four-stage R -> C -> M -> W integer pipeline.
module hazard_scheduler #(
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ValidInstruction_R,
    input  logic [$clog2(REG_COUNT)-1:0] rs1Adr_R,
    input  logic [$clog2(REG_COUNT)-1:0] rs2Adr_R,
    input  logic [$clog2(REG_COUNT)-1:0] rd1Adr_R,
    input  logic                         Rs1Used_R,
    input  logic                         Rs2Used_R,
    input  logic                         RegWrite_R,
    input  logic                         IsLoad_R,
    input  logic                         MultiCycle_R,
    input  logic                         PCRedirect_C,
    output logic                         Stall_I,
    output logic                         Stall_R,
    output logic                         Flush_R,
    output logic                         Flush_I,
    output logic                         Stall_C,
    output logic                         Flush_C,
    output logic [1:0]                   ForwardA_C,
    output logic [1:0]                   ForwardB_C,
    output logic                         Rs1Bypass_R,
    output logic                         Rs2Bypass_R
);

    localparam int unsigned   RA      = $clog2(REG_COUNT);
    localparam int unsigned   CW      = $clog2(MC_LATENCY);
    localparam logic [CW-1:0] MC_LOAD = CW'(MC_LATENCY - 1);

    // Shadow record of the instruction in C
    logic          r_c_valid;
    logic [RA-1:0] r_c_rd;
    logic          r_c_regwrite;
    logic          r_c_isload;
    logic [RA-1:0] r_c_rs1;
    logic [RA-1:0] r_c_rs2;
    logic          r_c_rs1used;
    logic          r_c_rs2used;
    logic          r_c_multicycle;

    // Shadow records of the instructions in M and W
    logic          r_m_valid;
    logic [RA-1:0] r_m_rd;
    logic          r_m_regwrite;
    logic          r_m_isload;
    logic          r_w_valid;
    logic [RA-1:0] r_w_rd;
    logic          r_w_regwrite;

    // Remaining hold cycles of the multi-cycle op sitting in C
    logic [CW-1:0] r_cnt;

    logic w_busy;
    logic w_c_wr;
    logic w_m_wr;
    logic w_w_wr;
    logic w_load_use;
    logic w_redirect;
    logic w_fwd_a_m;
    logic w_fwd_a_w;
    logic w_fwd_b_m;
    logic w_fwd_b_w;
    logic w_mc_enter;

    // Hazard-relevant writers exclude x0 so it never matches
    assign w_busy     = (r_cnt != '0);
    assign w_c_wr     = r_c_valid & r_c_regwrite & (r_c_rd != '0);
    assign w_m_wr     = r_m_valid & r_m_regwrite & (r_m_rd != '0);
    assign w_w_wr     = r_w_valid & r_w_regwrite & (r_w_rd != '0);
    assign w_load_use = w_c_wr & r_c_isload & ValidInstruction_R &
                        ((Rs1Used_R & (rs1Adr_R == r_c_rd)) |
                         (Rs2Used_R & (rs2Adr_R == r_c_rd)));
    assign w_redirect = PCRedirect_C & r_c_valid;
    assign w_fwd_a_m  = r_c_valid & r_c_rs1used & w_m_wr & (r_m_rd == r_c_rs1);
    assign w_fwd_a_w  = r_c_valid & r_c_rs1used & w_w_wr & (r_w_rd == r_c_rs1);
    assign w_fwd_b_m  = r_c_valid & r_c_rs2used & w_m_wr & (r_m_rd == r_c_rs2);
    assign w_fwd_b_w  = r_c_valid & r_c_rs2used & w_w_wr & (r_w_rd == r_c_rs2);
    assign w_mc_enter = ~Stall_C & ValidInstruction_R & ~Flush_R & MultiCycle_R;

    // Control outputs: reset > multi-cycle busy > redirect > load-use
    always_comb begin
        Stall_I     = 1'b0;
        Stall_R     = 1'b0;
        Flush_R     = 1'b0;
        Flush_I     = 1'b0;
        Stall_C     = 1'b0;
        Flush_C     = 1'b0;
        ForwardA_C  = 2'd0;
        ForwardB_C  = 2'd0;
        Rs1Bypass_R = 1'b0;
        Rs2Bypass_R = 1'b0;
        if (reset) begin
            if (w_busy) begin
                Stall_I = 1'b1;
                Stall_R = 1'b1;
                Stall_C = 1'b1;
                Flush_C = 1'b1;
            end else if (w_redirect) begin
                Flush_R = 1'b1;
                Flush_I = 1'b1;
            end else if (w_load_use) begin
                Stall_I = 1'b1;
                Stall_R = 1'b1;
                Flush_R = 1'b1;
            end
            ForwardA_C  = w_fwd_a_m ? 2'd1 : (w_fwd_a_w ? 2'd2 : 2'd0);
            ForwardB_C  = w_fwd_b_m ? 2'd1 : (w_fwd_b_w ? 2'd2 : 2'd0);
            Rs1Bypass_R = w_w_wr & (r_w_rd == rs1Adr_R) & Rs1Used_R;
            Rs2Bypass_R = w_w_wr & (r_w_rd == rs2Adr_R) & Rs2Used_R;
        end
    end

    // Advance shadow records and the multi-cycle hold counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_c_valid      <= 1'b0;
            r_c_rd         <= '0;
            r_c_regwrite   <= 1'b0;
            r_c_isload     <= 1'b0;
            r_c_rs1        <= '0;
            r_c_rs2        <= '0;
            r_c_rs1used    <= 1'b0;
            r_c_rs2used    <= 1'b0;
            r_c_multicycle <= 1'b0;
            r_m_valid      <= 1'b0;
            r_m_rd         <= '0;
            r_m_regwrite   <= 1'b0;
            r_m_isload     <= 1'b0;
            r_w_valid      <= 1'b0;
            r_w_rd         <= '0;
            r_w_regwrite   <= 1'b0;
            r_cnt          <= '0;
        end else begin
            if (!Stall_C) begin
                r_c_valid      <= ValidInstruction_R & ~Flush_R;
                r_c_rd         <= rd1Adr_R;
                r_c_regwrite   <= RegWrite_R;
                r_c_isload     <= IsLoad_R;
                r_c_rs1        <= rs1Adr_R;
                r_c_rs2        <= rs2Adr_R;
                r_c_rs1used    <= Rs1Used_R;
                r_c_rs2used    <= Rs2Used_R;
                r_c_multicycle <= MultiCycle_R;
            end
            r_m_valid    <= r_c_valid & ~Flush_C;
            r_m_rd       <= r_c_rd;
            r_m_regwrite <= r_c_regwrite;
            r_m_isload   <= r_c_isload;
            r_w_valid    <= r_m_valid;
            r_w_rd       <= r_m_rd;
            r_w_regwrite <= r_m_regwrite;
            if (w_busy) begin
                r_cnt <= r_cnt - CW'(1);
            end else if (w_mc_enter) begin
                r_cnt <= MC_LOAD;
            end
        end
    end

    // Simulation checks: no forwarding from a load in M, busy only with a multi-cycle op in C
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!((w_fwd_a_m | w_fwd_b_m) & r_m_isload))
                else $error("hazard_scheduler: operand forwarded from a load still in M");
            assert (!w_busy || (r_c_valid && r_c_multicycle))
                else $error("hazard_scheduler: busy without a multi-cycle op in C");
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed pipeline sequences; the driver queues the
// hand-computed control vector per cycle, a negedge monitor pops and compares.
module tb_hazard_scheduler;

    localparam int unsigned REG_COUNT  = 32;
    localparam int unsigned MC_LATENCY = 4;
    localparam int unsigned RA         = $clog2(REG_COUNT);

    typedef struct packed {
        logic          v;
        logic [RA-1:0] rs1;
        logic [RA-1:0] rs2;
        logic [RA-1:0] rd;
        logic          u1;
        logic          u2;
        logic          rw;
        logic          ld;
        logic          mc;
    } instr_t;

    typedef struct packed {
        logic       si;
        logic       sr;
        logic       fr;
        logic       fi;
        logic       sc;
        logic       fc;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       b1;
        logic       b2;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ValidInstruction_R;
    logic [RA-1:0] rs1Adr_R;
    logic [RA-1:0] rs2Adr_R;
    logic [RA-1:0] rd1Adr_R;
    logic          Rs1Used_R;
    logic          Rs2Used_R;
    logic          RegWrite_R;
    logic          IsLoad_R;
    logic          MultiCycle_R;
    logic          PCRedirect_C;
    logic          Stall_I;
    logic          Stall_R;
    logic          Flush_R;
    logic          Flush_I;
    logic          Stall_C;
    logic          Flush_C;
    logic [1:0]    ForwardA_C;
    logic [1:0]    ForwardB_C;
    logic          Rs1Bypass_R;
    logic          Rs2Bypass_R;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(
        .REG_COUNT (REG_COUNT),
        .MC_LATENCY(MC_LATENCY)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ValidInstruction_R(ValidInstruction_R),
        .rs1Adr_R          (rs1Adr_R),
        .rs2Adr_R          (rs2Adr_R),
        .rd1Adr_R          (rd1Adr_R),
        .Rs1Used_R         (Rs1Used_R),
        .Rs2Used_R         (Rs2Used_R),
        .RegWrite_R        (RegWrite_R),
        .IsLoad_R          (IsLoad_R),
        .MultiCycle_R      (MultiCycle_R),
        .PCRedirect_C      (PCRedirect_C),
        .Stall_I           (Stall_I),
        .Stall_R           (Stall_R),
        .Flush_R           (Flush_R),
        .Flush_I           (Flush_I),
        .Stall_C           (Stall_C),
        .Flush_C           (Flush_C),
        .ForwardA_C        (ForwardA_C),
        .ForwardB_C        (ForwardB_C),
        .Rs1Bypass_R       (Rs1Bypass_R),
        .Rs2Bypass_R       (Rs2Bypass_R)
    );

    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t alu(input int rd, input int rs1, input int rs2,
                                   input bit u1, input bit u2);
        instr_t i;
        i     = '0;
        i.v   = 1'b1;
        i.rd  = RA'(rd);
        i.rs1 = RA'(rs1);
        i.rs2 = RA'(rs2);
        i.u1  = u1;
        i.u2  = u2;
        i.rw  = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw(input int rd, input int rs1);
        instr_t i;
        i    = alu(rd, rs1, 0, 1'b1, 1'b0);
        i.ld = 1'b1;
        return i;
    endfunction

    function automatic instr_t mcop(input int rd, input int rs1, input int rs2);
        instr_t i;
        i    = alu(rd, rs1, rs2, 1'b1, 1'b1);
        i.mc = 1'b1;
        return i;
    endfunction

    function automatic exp_t ex(input bit si, input bit sr, input bit fr, input bit fi,
                                input bit sc, input bit fc, input int fa, input int fb,
                                input bit b1, input bit b2);
        exp_t e;
        e.si = si;
        e.sr = sr;
        e.fr = fr;
        e.fi = fi;
        e.sc = sc;
        e.fc = fc;
        e.fa = 2'(fa);
        e.fb = 2'(fb);
        e.b1 = b1;
        e.b2 = b2;
        return e;
    endfunction

    // Drive one cycle of R-stage inputs and queue the expected control vector
    task automatic step(input string nm, input logic rst, input instr_t ins,
                        input logic redir, input exp_t e);
        @(posedge clk);
        #1;
        reset              = rst;
        ValidInstruction_R = ins.v;
        rs1Adr_R           = ins.rs1;
        rs2Adr_R           = ins.rs2;
        rd1Adr_R           = ins.rd;
        Rs1Used_R          = ins.u1;
        Rs2Used_R          = ins.u2;
        RegWrite_R         = ins.rw;
        IsLoad_R           = ins.ld;
        MultiCycle_R       = ins.mc;
        PCRedirect_C       = redir;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) begin
            step("drain", 1'b1, nop(), 1'b0, '0);
        end
    endtask

    // Monitor: compare the DUT control vector mid-cycle against the queued expectation
    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (q_exp.size() != 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            a  = {Stall_I, Stall_R, Flush_R, Flush_I, Stall_C, Flush_C,
                  ForwardA_C, ForwardB_C, Rs1Bypass_R, Rs2Bypass_R};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got si sr fr fi sc fc fa fb b1 b2 = %b, expected %b",
                         nm, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t busy;
        busy = ex(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);

        reset              = 1'b0;
        ValidInstruction_R = 1'b0;
        rs1Adr_R           = '0;
        rs2Adr_R           = '0;
        rd1Adr_R           = '0;
        Rs1Used_R          = 1'b0;
        Rs2Used_R          = 1'b0;
        RegWrite_R         = 1'b0;
        IsLoad_R           = 1'b0;
        MultiCycle_R       = 1'b0;
        PCRedirect_C       = 1'b0;

        step("rst0", 1'b0, nop(), 1'b0, '0);
        step("rst1", 1'b0, alu(5, 1, 2, 1, 1), 1'b0, '0);

        // lw x5 ; add x6,x5,x1
        step("t1_lw",       1'b1, lw(5, 2),              1'b0, '0);
        step("t1_loaduse",  1'b1, alu(6, 5, 1, 1, 1),    1'b0, ex(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        step("t1_held",     1'b1, alu(6, 5, 1, 1, 1),    1'b0, '0);
        step("t1_fwdW",     1'b1, nop(),                 1'b0, ex(0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        drain();

        // addi x3,x0,1 ; addi x3,x3,1 ; add x4,x3,x3 ; add x8,x3,x3
        step("t2_addi1",    1'b1, alu(3, 0, 0, 1, 0),    1'b0, '0);
        step("t2_addi2",    1'b1, alu(3, 3, 0, 1, 0),    1'b0, '0);
        step("t2_fwdM",     1'b1, alu(4, 3, 3, 1, 1),    1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("t2_mbeatsw",  1'b1, alu(8, 3, 3, 1, 1),    1'b0, ex(0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        step("t2_fwdW",     1'b1, nop(),                 1'b0, ex(0, 0, 0, 0, 0, 0, 2, 2, 0, 0));
        drain();

        // x0 writers never forward, stall or bypass
        step("t3_addi_x0",  1'b1, alu(0, 0, 0, 1, 0),    1'b0, '0);
        step("t3_lw_x0",    1'b1, lw(0, 0),              1'b0, '0);
        step("t3_use_x0",   1'b1, alu(7, 0, 0, 1, 1),    1'b0, '0);
        step("t3_byp_x0",   1'b1, alu(9, 0, 0, 1, 1),    1'b0, '0);
        drain();

        // multi-cycle op then dependent; redirect ignored while busy
        step("t4_mul",      1'b1, mcop(10, 1, 2),        1'b0, '0);
        step("t4_busy1",    1'b1, alu(11, 10, 0, 1, 0),  1'b0, busy);
        step("t4_busy2",    1'b1, alu(11, 10, 0, 1, 0),  1'b1, busy);
        step("t4_busy3",    1'b1, alu(11, 10, 0, 1, 0),  1'b0, busy);
        step("t4_last",     1'b1, alu(11, 10, 0, 1, 0),  1'b0, '0);
        step("t4_fwdM",     1'b1, nop(),                 1'b0, ex(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        drain();

        // redirect from a load in C overrides the load-use stall
        step("t5_lw",       1'b1, lw(12, 1),             1'b0, '0);
        step("t5_redir",    1'b1, alu(13, 12, 0, 1, 0),  1'b1, ex(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        step("t5_redir_cinv", 1'b1, alu(14, 13, 0, 1, 0), 1'b1, '0);
        step("t5_no_leak",  1'b1, alu(15, 12, 0, 1, 0),  1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        drain();

        // reset in the middle of a multi-cycle op, then a fresh one
        step("t6_mul",      1'b1, mcop(16, 1, 2),        1'b0, '0);
        step("t6_busy1",    1'b1, alu(17, 16, 0, 1, 0),  1'b0, busy);
        step("t6_rst_busy", 1'b0, alu(17, 16, 0, 1, 0),  1'b0, '0);
        step("t6_rst_hold", 1'b0, alu(17, 16, 0, 1, 0),  1'b1, '0);
        step("t6_post_rst", 1'b1, alu(17, 16, 0, 1, 0),  1'b0, '0);
        step("t6_idle",     1'b1, mcop(18, 3, 4),        1'b0, '0);
        step("t6_busy_a",   1'b1, nop(),                 1'b0, busy);
        step("t6_busy_b",   1'b1, nop(),                 1'b0, busy);
        step("t6_busy_c",   1'b1, nop(),                 1'b0, busy);
        step("t6_done",     1'b1, nop(),                 1'b0, '0);
        drain();

        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations left unchecked", q_exp.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
